// File: rtl/alu_operand_register_file_if.sv
// alu_operand_register_file_if: write/read bus between the datapath controller and the ALU operand register file
interface alu_operand_register_file_if #(
    parameter int WIDTH = 16,
    parameter int NGP   = 4,
    parameter int NSCR  = 4
);
    localparam int SW = $clog2(NGP + NSCR);
    logic [WIDTH-1:0] data;
    logic [3:0]       flags;
    logic [2:0]       cond;
    logic [NGP-1:0]   reg_sel;
    logic [NSCR-1:0]  scr_sel;
    logic [2:0]       fun_sel;
    logic [SW-1:0]    out_a_sel;
    logic [SW-1:0]    out_b_sel;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    modport master (
        output data, flags, cond, reg_sel, scr_sel, fun_sel, out_a_sel, out_b_sel,
        input  out_a, out_b
    );
    modport slave (
        input  data, flags, cond, reg_sel, scr_sel, fun_sel, out_a_sel, out_b_sel,
        output out_a, out_b
    );
endinterface

// File: rtl/alu_operand_register_file.sv
// alu_operand_register_file: general + scratch registers feeding ALU operands, with flag-conditioned writes
module alu_operand_register_file #(
    parameter int WIDTH = 16,
    parameter int NGP   = 4,
    parameter int NSCR  = 4
) (
    input logic clk,
    input logic rst_n,
    alu_operand_register_file_if.slave bus
);
    localparam int NREG = NGP + NSCR;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] nxt  [NREG];
    logic [NREG-1:0]  en;
    logic [7:0]       cond_vec;
    logic             we;
    logic [7:0]       lo;
    // Flag condition picks the write enable; a false condition masks every select, even undriven ones
    always_comb begin
        cond_vec = {bus.flags[0], ~bus.flags[1], bus.flags[1], ~bus.flags[2],
                    bus.flags[2], ~bus.flags[3], bus.flags[3], 1'b1};
        we = cond_vec[bus.cond];
        en = we ? {bus.scr_sel, bus.reg_sel} : '0;
    end
    // Every register computes the shared operation on its own value; only enabled ones commit it
    always_comb begin
        lo = bus.data[7:0];
        for (int k = 0; k < NREG; k++) begin
            nxt[k] = regs[k];
            case (bus.fun_sel)
                3'b000: nxt[k] = regs[k] - WIDTH'(1);
                3'b001: nxt[k] = regs[k] + WIDTH'(1);
                3'b010: nxt[k] = bus.data;
                3'b011: nxt[k] = '0;
                3'b100: nxt[k] = WIDTH'(lo);
                3'b101: nxt[k][7:0] = lo;
                3'b110: nxt[k][15:8] = lo;
                default: nxt[k] = {{(WIDTH-8){lo[7]}}, lo};
            endcase
        end
    end
    // Asynchronous clear of all registers; otherwise commit enabled registers on the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) if (en[k]) regs[k] <= nxt[k];
        end
    end
    assign bus.out_a = regs[bus.out_a_sel];
    assign bus.out_b = regs[bus.out_b_sel];
endmodule

// File: tb/tb_alu_operand_register_file.sv
// tb_alu_operand_register_file: directed and random checks against a behavioural register-file model
module tb_alu_operand_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_operand_register_file_if bus();
    alu_operand_register_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [15:0] model [8];
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_true(logic [2:0] c, logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[3] == 1'b1;
            3'd2: return f[3] == 1'b0;
            3'd3: return f[2] == 1'b1;
            3'd4: return f[2] == 1'b0;
            3'd5: return f[1] == 1'b1;
            3'd6: return f[1] == 1'b0;
            default: return f[0] == 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] apply(logic [2:0] fun, logic [15:0] q, logic [15:0] d);
        int qi = int'(q);
        int di = int'(d);
        case (fun)
            3'd0: return 16'((qi + 65535) % 65536);
            3'd1: return 16'((qi + 1) % 65536);
            3'd2: return d;
            3'd3: return 16'd0;
            3'd4: return 16'(di % 256);
            3'd5: return 16'((qi / 256) * 256 + di % 256);
            3'd6: return 16'((di % 256) * 256 + qi % 256);
            default: return 16'((di % 256 >= 128) ? di % 256 + 65280 : di % 256);
        endcase
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 8; k++) model[k] = 16'd0;
    endtask

    task automatic drive(logic [2:0] c, logic [3:0] f, logic [3:0] rs, logic [3:0] ss,
                         logic [2:0] fn, logic [15:0] d, logic [2:0] a, logic [2:0] b);
        bus.cond = c;
        bus.flags = f;
        bus.reg_sel = rs;
        bus.scr_sel = ss;
        bus.fun_sel = fn;
        bus.data = d;
        bus.out_a_sel = a;
        bus.out_b_sel = b;
    endtask

    task automatic tick();
        logic [7:0] en;
        @(posedge clk);
        en = {bus.scr_sel, bus.reg_sel};
        if (rst_n && cond_true(bus.cond, bus.flags))
            for (int k = 0; k < 8; k++) if (en[k]) model[k] = apply(bus.fun_sel, model[k], bus.data);
        #1;
    endtask

    task automatic idle();
        bus.reg_sel = 4'd0;
        bus.scr_sel = 4'd0;
    endtask

    task automatic peek(string name, logic [2:0] sel, logic [15:0] exp);
        bus.out_a_sel = sel;
        #1;
        chk(name, bus.out_a, exp);
    endtask

    // Every falling edge: both operand outputs must equal the model's stored value
    always @(negedge clk) begin
        chk("cyc_out_a", bus.out_a, model[bus.out_a_sel]);
        chk("cyc_out_b", bus.out_b, model[bus.out_b_sel]);
    end

    initial begin
        logic [15:0] specials [5] = '{16'h0000, 16'hFFFF, 16'h0080, 16'h007F, 16'hFF7F};
        logic [7:0] one_hot;
        logic [15:0] d;
        clear_model();
        drive(3'd0, 4'd0, 4'd0, 4'd0, 3'd0, 16'd0, 3'd0, 3'd5);
        #1;
        chk("reset_out_a", bus.out_a, 16'h0000);
        chk("reset_out_b", bus.out_b, 16'h0000);
        #1 rst_n = 1'b1;
        // Burst of loads interrupted by an asynchronous reset
        for (int i = 0; i < 5; i++) begin
            one_hot = 8'(1 << i);
            drive(3'd0, 4'd0, one_hot[3:0], one_hot[7:4], 3'd2, 16'(16'h1111 * (i + 1)), 3'(i), 3'(i));
            tick();
        end
        peek("burst_r3", 3'd2, 16'h3333);
        #1 rst_n = 1'b0;
        clear_model();
        idle();
        #1;
        chk("async_rst_a", bus.out_a, 16'h0000);
        chk("async_rst_b", bus.out_b, 16'h0000);
        for (int k = 0; k < 8; k++) peek($sformatf("async_rst_reg%0d", k), 3'(k), 16'h0000);
        #1 rst_n = 1'b1;
        tick();
        // Plain load with no bypass
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd2, 16'h1234, 3'd0, 3'd1);
        #2;
        chk("load_no_bypass", bus.out_a, 16'h0000);
        tick();
        chk("load_r1", bus.out_a, 16'h1234);
        chk("load_r2_hold", bus.out_b, 16'h0000);
        idle();
        peek("load_s4_hold", 3'd7, 16'h0000);
        // Increment and decrement wrap
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd2, 16'hFFFF, 3'd0, 3'd0);
        tick();
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd1, 16'h0000, 3'd0, 3'd0);
        tick();
        peek("inc_wrap", 3'd0, 16'h0000);
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd0, 16'h0000, 3'd0, 3'd0);
        tick();
        tick();
        idle();
        peek("dec_wrap", 3'd0, 16'hFFFE);
        // Byte operations on R3
        drive(3'd0, 4'd0, 4'b0100, 4'd0, 3'd2, 16'hABCD, 3'd2, 3'd2);
        tick();
        drive(3'd0, 4'd0, 4'b0100, 4'd0, 3'd5, 16'h0080, 3'd2, 3'd2);
        tick();
        idle();
        peek("byte_low", 3'd2, 16'hAB80);
        drive(3'd0, 4'd0, 4'b0100, 4'd0, 3'd7, 16'h0080, 3'd2, 3'd2);
        tick();
        idle();
        peek("byte_sext", 3'd2, 16'hFF80);
        drive(3'd0, 4'd0, 4'b0100, 4'd0, 3'd4, 16'h0080, 3'd2, 3'd2);
        tick();
        idle();
        peek("byte_zext", 3'd2, 16'h0080);
        drive(3'd0, 4'd0, 4'b0100, 4'd0, 3'd6, 16'h0080, 3'd2, 3'd2);
        tick();
        idle();
        peek("byte_high", 3'd2, 16'h8080);
        // Conditional clear of scratch registers on Z
        drive(3'd0, 4'd0, 4'd0, 4'b1111, 3'd2, 16'h5A5A, 3'd4, 3'd7);
        tick();
        drive(3'd1, 4'b0000, 4'd0, 4'b1111, 3'd3, 16'h0000, 3'd4, 3'd7);
        tick();
        chk("cond_z_false_s1", bus.out_a, 16'h5A5A);
        chk("cond_z_false_s4", bus.out_b, 16'h5A5A);
        drive(3'd1, 4'b1000, 4'd0, 4'b1111, 3'd3, 16'h0000, 3'd5, 3'd6);
        tick();
        chk("cond_z_true_s2", bus.out_a, 16'h0000);
        chk("cond_z_true_s3", bus.out_b, 16'h0000);
        // Read-modify-write with both operands on R1
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd2, 16'h0005, 3'd0, 3'd0);
        tick();
        drive(3'd0, 4'd0, 4'b0001, 4'd0, 3'd1, 16'h0000, 3'd0, 3'd0);
        #2;
        chk("rmw_before_a", bus.out_a, 16'h0005);
        chk("rmw_before_b", bus.out_b, 16'h0005);
        tick();
        chk("rmw_after_a", bus.out_a, 16'h0006);
        chk("rmw_after_b", bus.out_b, 16'h0006);
        // Random traffic, occasionally interrupted by an asynchronous reset
        for (int n = 0; n < 800; n++) begin
            d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
            drive(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom_range(0, 7)), d, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                clear_model();
                #1;
                chk("rand_async_rst", bus.out_a, 16'h0000);
                #1 rst_n = 1'b1;
            end
            tick();
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
